// File: rtl/mem_rq_responder.sv
// Memory-side responder for the core's request/response get/put ports: word RAM,
// LED MMIO register, unmapped-access error reporting and a credit-checked response FIFO.
module mem_rq_responder #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 LGSZW     = 8,
  parameter int                 RSP_DEPTH = 2,
  parameter bit                 WRITE_RSP = 1'b0,
  parameter logic [ADDR_W-1:0]  LED_ADDR  = 32'h8000_0000,
  parameter logic [DATA_W-1:0]  ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [ADDR_W+DATA_W:0]   rq_data,
  input  logic                     rq_rdy,
  output logic                     rq_en,
  output logic [DATA_W-1:0]        rs_data,
  input  logic                     rs_rdy,
  output logic                     rs_en,
  output logic                     led,
  output logic                     err,
  output logic [15:0]              err_count
);

  localparam int LGB       = $clog2(DATA_W / 8);
  localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
  localparam int MEM_WORDS = 1 << LGSZW;

  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_LED,
    SRC_ERR,
    SRC_ZERO
  } src_e;

  logic [ADDR_W-1:0] rq_addr;
  logic              rq_write;
  logic [DATA_W-1:0] rq_wdata;
  logic [LGSZW-1:0]  rq_index;
  logic              in_ram;
  logic              is_led;
  logic              resp_needed;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] ram_rdata_q;

  logic [DATA_W-1:0] fifo_q [RSP_DEPTH];
  logic [DATA_W-1:0] fifo_d [RSP_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              s1_valid_q, s1_valid_d;
  src_e              s1_src_q, s1_src_d;
  logic              led_q, led_d;
  logic              err_q, err_d;
  logic [15:0]       err_count_q, err_count_d;

  logic              fifo_nonempty;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occ;
  logic [DATA_W-1:0] s1_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rq_addr     = rq_data[ADDR_W+DATA_W:DATA_W+1];
  assign rq_write    = rq_data[DATA_W];
  assign rq_wdata    = rq_data[DATA_W-1:0];
  assign rq_index    = rq_addr[LGB+LGSZW-1:LGB];
  assign in_ram      = (rq_addr >> (LGB + LGSZW)) == '0;
  assign is_led      = !in_ram && (rq_addr == LED_ADDR);
  assign resp_needed = !rq_write || WRITE_RSP;

  assign fifo_nonempty = count_q != '0;
  assign pop           = fifo_nonempty && rs_rdy;
  assign push          = s1_valid_q;
  assign occ           = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q};

  // A slot freed by this cycle's pop can be promised to the new request.
  assign rq_en   = rq_rdy && (!resp_needed || (occ < (CNT_W+1)'(RSP_DEPTH)) || pop);
  assign rs_en   = pop;
  assign rs_data = fifo_nonempty ? fifo_q[head_q] : '0;
  assign led       = led_q;
  assign err       = err_q;
  assign err_count = err_count_q;

  always_comb begin
    s1_data = '0;
    case (s1_src_q)
      SRC_RAM:  s1_data = ram_rdata_q;
      SRC_LED:  s1_data = {{(DATA_W-1){1'b0}}, led_q};
      SRC_ERR:  s1_data = ERR_DATA;
      default:  s1_data = '0;
    endcase
  end

  always_comb begin
    s1_valid_d  = 1'b0;
    s1_src_d    = s1_src_q;
    led_d       = led_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;

    if (rq_en) begin
      s1_valid_d = resp_needed;
      if (in_ram) begin
        s1_src_d = rq_write ? SRC_ZERO : SRC_RAM;
      end else if (is_led) begin
        s1_src_d = rq_write ? SRC_ZERO : SRC_LED;
        if (rq_write) led_d = rq_wdata[0];
      end else begin
        s1_src_d    = rq_write ? SRC_ZERO : SRC_ERR;
        err_d       = 1'b1;
        err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
      end
    end

    if (push) begin
      fifo_d[tail_q] = s1_data;
      tail_d         = ptr_inc(tail_q);
    end
    if (pop) head_d = ptr_inc(head_q);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // The RAM is deliberately left out of reset so committed writes survive it.
  always_ff @(posedge CLK) begin
    if (rq_en && in_ram) begin
      if (rq_write) mem[rq_index] <= rq_wdata;
      else          ram_rdata_q   <= mem[rq_index];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fifo_q      <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_src_q    <= SRC_ZERO;
      led_q       <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      s1_valid_q  <= s1_valid_d;
      s1_src_q    <= s1_src_d;
      led_q       <= led_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
    !(push && !pop && (count_q == CNT_W'(RSP_DEPTH))));

endmodule
